// File: rtl/tut3_verilog_regincr_pkg.sv
// Shared constants and helpers for the regincr pipeline family.
package tut3_verilog_regincr_pkg;

    localparam int unsigned MSG_W       = 8;
    localparam int unsigned NSTAGES_MIN = 1;
    localparam int unsigned NSTAGES_MAX = 16;

    typedef logic [MSG_W-1:0] msg_t;

    // Modulo-256 decrement applied by every stage on capture.
    function automatic msg_t msg_decr(input msg_t m);
        return m - msg_t'(1);
    endfunction

endpackage

// File: rtl/tut3_verilog_regincr_RegDecrStage.sv
// Single elastic decrement stage: registered val/data, advanced by the
// stage ready computed in the parent's ready chain.
module tut3_verilog_regincr_RegDecrStage
    import tut3_verilog_regincr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [MSG_W-1:0] in_msg,
    input  logic             rdy,
    output logic             out_val,
    output logic [MSG_W-1:0] out_msg
);

    // Data only moves when a valid message is captured; bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
        end else if (rdy) begin
            out_val <= in_val;
            if (in_val) begin
                out_msg <= msg_decr(in_msg);
            end
        end
    end

endmodule

// File: rtl/reg_decr_nstage_valrdy.sv
// Elastic N-stage registered decrementer with val/rdy on both ends and an
// occupancy counter tracking the number of valid stages.
module reg_decr_nstage_valrdy
    import tut3_verilog_regincr_pkg::*;
#(
    parameter int unsigned p_nstages = 2
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_val,
    output logic                             in_rdy,
    input  logic [MSG_W-1:0]                 in_msg,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic [MSG_W-1:0]                 out_msg,
    output logic [$clog2(p_nstages+1)-1:0]   occupancy
);

    localparam int unsigned LAST  = p_nstages - 1;
    localparam int unsigned OCC_W = $clog2(p_nstages + 1);

    if (p_nstages < NSTAGES_MIN || p_nstages > NSTAGES_MAX) begin : g_bad_nstages
        $error("reg_decr_nstage_valrdy: p_nstages out of range");
    end

    logic [p_nstages-1:0] val;
    logic [p_nstages-1:0] rdy;
    msg_t                 data [p_nstages];

    for (genvar i = 0; i < p_nstages; i++) begin : g_stage
        logic s_val;
        msg_t s_msg;

        if (i == 0) begin : g_head
            assign s_val = in_val;
            assign s_msg = in_msg;
        end else begin : g_body
            assign s_val = val[i-1];
            assign s_msg = data[i-1];
        end

        // Unrolled ready chain: a stage can advance unless it and every
        // stage downstream of it is full while the sink stalls.
        assign rdy[i] = out_rdy || !(&val[p_nstages-1:i]);

        tut3_verilog_regincr_RegDecrStage u_stage (
            .clk     (clk),
            .reset   (reset),
            .in_val  (s_val),
            .in_msg  (s_msg),
            .rdy     (rdy[i]),
            .out_val (val[i]),
            .out_msg (data[i])
        );
    end

    assign in_rdy  = rdy[0] && !reset;
    assign out_val = val[LAST];
    assign out_msg = data[LAST];

    logic in_xfer_c;
    logic out_xfer_c;

    assign in_xfer_c  = in_val && in_rdy;
    assign out_xfer_c = out_val && out_rdy;

    // Occupancy moves only when exactly one end transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else if (in_xfer_c && !out_xfer_c) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (!in_xfer_c && out_xfer_c) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

// File: doc/reg_decr_nstage_valrdy.md
# reg_decr_nstage_valrdy

Elastic, parameterized-depth registered decrementer pipeline with val/rdy handshakes on both ends. It is the inverse-direction counterpart of the registered incrementer chain: each accepted 8-bit message leaves with `p_nstages` subtracted (mod 256). It carries full backpressure, in-order delivery, one message per cycle of throughput, and an occupancy count. It sits in the regincr subproject and is used as a variable-latency test target for val/rdy sources and sinks.

## Interface
- `p_nstages`, default 2: number of decrement stages; legal range 1..16.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `in_val`  in  1  upstream message valid.
- `in_rdy`  out  1  block can accept a message this cycle.
- `in_msg`  in  8  upstream message.
- `out_val`  out  1  message at the output is valid.
- `out_rdy`  in  1  downstream accepts this cycle.
- `out_msg`  out  8  output message: accepted `in_msg` minus `p_nstages`, mod 256.
- `occupancy`  out  $clog2(p_nstages+1)  number of valid messages currently held in stages.

## Operation
- Stage i (0..p_nstages-1) holds `val[i]` and `data[i]`. Stage 0 captures from the input; stage i captures from stage i-1.
- On capture, a stage stores its source value minus 1 (8-bit wrap: 0x00 becomes 0xFF).
- Per-stage ready: `rdy[p_nstages-1] = !val[last] || out_rdy`; `rdy[i] = !val[i] || rdy[i+1]`. The ready chain is combinational, so a full pipeline that is draining accepts a new message in the same cycle.
- `in_rdy = rdy[0] && !reset`. `out_val = val[last]`. `out_msg = data[last]`.
- Stage i advances when `rdy[i]`:
  - `val[i]` takes `val[i-1]` (or `in_val` for stage 0).
  - `data[i]` takes the decremented source only when the source is valid. Otherwise `data[i]` holds.
- A stage that is not ready holds both `val` and `data`.
- A transfer occurs only when val and rdy are both high on the same edge. Messages are never dropped, duplicated, or reordered.
- `occupancy` is a registered counter:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Unchanged when both or neither occur.
  - Always equals the popcount of `val`.
- Reset, including mid-operation: all `val` cleared, `data` cleared to 0x00, `occupancy` 0. Any messages in flight are discarded. `in_rdy` is 0 while reset is high.

## Timing
- Reset values: `out_val`=0, `out_msg`=0x00, `occupancy`=0, `in_rdy`=0 during reset and 1 on the first cycle after reset.
- Latency: a message accepted at edge t appears with `out_val`=1 in the cycle after edge t+p_nstages-1, i.e. p_nstages cycles, when no stalls occur.
- Throughput: 1 message/cycle sustained when `out_rdy`=1.
- With `out_rdy` held at 0, exactly p_nstages messages are accepted. `in_rdy` then drops combinationally once all stages are valid.
- When the pipeline is full and `out_rdy`=1, input and output transfer on the same edge and `occupancy` is unchanged.
- `out_msg`/`out_val` must stay stable while `out_val`=1 and `out_rdy`=0.

## Structure
- Shared package `tut3_verilog_regincr_pkg`: message width constant (8) and the stage-count bounds.
- One sub-module: `tut3_verilog_regincr_RegDecrStage`. It is a single elastic stage: registered val/data with a decrement on capture, upstream val/rdy in, downstream val/rdy out.
- The top level instantiates p_nstages stages in a generate loop, chains val/rdy/msg between them, and adds the occupancy counter.

## Test plan
- **Single message:** p_nstages=2, `out_rdy`=1, send 0x05 once → `out_val` in exactly 2 cycles with `out_msg`=0x03. `occupancy` goes 1, 1, 0.
- **Wrap-around:** p_nstages=3, send 0x01, then 0x00 → outputs 0xFE, then 0xFD.
- **Streaming:** p_nstages=4, send 0x10..0x1F back-to-back with `out_rdy`=1 → 0x0C..0x1B emitted on consecutive cycles with no bubbles, and `in_rdy` never deasserts.
- **Backpressure:** p_nstages=3, `out_rdy`=0, `in_val` held with 0x20, 0x21, 0x22, 0x23 → only three are accepted and `in_rdy`=0 with `occupancy`=3. Then raise `out_rdy` → 0x1D, 0x1E, 0x1F, 0x20 arrive in order, with simultaneous in/out transfers while full.
- **Random stall:** p_nstages=2, random `in_val`/`out_rdy` over 500 messages → a scoreboard matches in-order `msg-2` (mod 256), and `occupancy` always equals the reference model count.
- **Reset mid-operation:** fill 2 of 4 stages, assert reset one cycle → `out_val`=0, `occupancy`=0, `in_rdy`=0 during reset. No stale message appears afterwards, and the next input 0x09 exits as 0x05.
